// File: rtl/cmd_sequencer_if.sv
// Host-side command/response handshake between the UART command receiver,
// the UART transmitter and the command sequencer.
interface cmd_sequencer_if;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_sent;

  modport master (
    output cmd_rdy, cmd, data, resp_sent,
    input  clr_cmd_rdy, send_resp, resp
  );

  modport slave (
    input  cmd_rdy, cmd, data, resp_sent,
    output clr_cmd_rdy, send_resp, resp
  );
endinterface

// File: rtl/cmd_sequencer.sv
// Command sequencer: decodes host commands, owns flight setpoints, sequences calibration.
// Optional link-loss watchdog is built only when CMD_WDOG_EN is defined.
//
// state    | meaning
// IDLE     | ready to consume the next pending command
// CAL_WAIT | calibration started, waiting for cal_done or timeout
// WAIT_TX  | response byte handed to UART TX, waiting for resp_sent
module cmd_sequencer #(
  parameter logic [25:0] CAL_TMO  = 26'h3FFFFFF,
  parameter logic [25:0] WDOG_CYC = 26'h3FFFFFF
) (
  input  logic               clk,
  input  logic               rst,
  cmd_sequencer_if.slave     bus,
  input  logic               cal_done,
  output logic               strt_cal,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic [8:0]         thrst,
  output logic               motors_off,
  output logic               wdog_trip
);

  typedef enum logic [1:0] {IDLE, CAL_WAIT, WAIT_TX} state_t;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_BAD = 8'hEE;
  localparam logic [7:0] RESP_TMO = 8'hE1;

  state_t             state, state_nxt;
  logic [25:0]        cal_cnt, cal_cnt_nxt;
  logic               clr_nxt, send_nxt, strt_nxt, motors_nxt;
  logic [7:0]         resp_nxt;
  logic signed [15:0] ptch_nxt, roll_nxt, yaw_nxt;
  logic [8:0]         thrst_nxt;
  logic               consume;
  logic               wdog_hit;

  assign consume = (state == IDLE) && bus.cmd_rdy;

`ifdef CMD_WDOG_EN
  logic [25:0] wdog_cnt;

  // A command consumed on the terminal cycle counts as link activity and wins.
  assign wdog_hit = (wdog_cnt == WDOG_CYC) && !consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else begin
      wdog_trip <= wdog_hit;
      if (consume || wdog_hit)
        wdog_cnt <= '0;
      else if (!motors_off && (thrst != '0))
        wdog_cnt <= wdog_cnt + 26'd1;
    end
  end
`else
  logic unused_wdog_cyc;

  assign unused_wdog_cyc = ^WDOG_CYC;
  assign wdog_hit        = 1'b0;
  assign wdog_trip       = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cal_cnt_nxt = cal_cnt;
    clr_nxt     = 1'b0;
    send_nxt    = 1'b0;
    strt_nxt    = 1'b0;
    resp_nxt    = bus.resp;
    motors_nxt  = motors_off;
    ptch_nxt    = d_ptch;
    roll_nxt    = d_roll;
    yaw_nxt     = d_yaw;
    thrst_nxt   = thrst;

    case (state)
      IDLE: begin
        if (bus.cmd_rdy) begin
          clr_nxt   = 1'b1;
          send_nxt  = 1'b1;
          resp_nxt  = RESP_ACK;
          state_nxt = WAIT_TX;
          case (bus.cmd)
            8'h02: ptch_nxt  = $signed(bus.data);
            8'h03: roll_nxt  = $signed(bus.data);
            8'h04: yaw_nxt   = $signed(bus.data);
            8'h05: thrst_nxt = bus.data[8:0];
            8'h06: begin
              // Response is deferred until calibration resolves.
              send_nxt    = 1'b0;
              resp_nxt    = bus.resp;
              strt_nxt    = 1'b1;
              motors_nxt  = 1'b0;
              cal_cnt_nxt = '0;
              state_nxt   = CAL_WAIT;
            end
            8'h07: begin
              ptch_nxt  = '0;
              roll_nxt  = '0;
              yaw_nxt   = '0;
              thrst_nxt = '0;
            end
            8'h08: begin
              motors_nxt = 1'b1;
              thrst_nxt  = '0;
            end
            default: resp_nxt = RESP_BAD;
          endcase
        end
      end
      CAL_WAIT: begin
        if (cal_done) begin
          send_nxt  = 1'b1;
          resp_nxt  = RESP_ACK;
          state_nxt = WAIT_TX;
        end else if (cal_cnt == CAL_TMO) begin
          send_nxt   = 1'b1;
          resp_nxt   = RESP_TMO;
          motors_nxt = 1'b1;
          state_nxt  = WAIT_TX;
        end else begin
          cal_cnt_nxt = cal_cnt + 26'd1;
        end
      end
      WAIT_TX: begin
        if (bus.resp_sent)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (wdog_hit) begin
      ptch_nxt  = '0;
      roll_nxt  = '0;
      yaw_nxt   = '0;
      thrst_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cal_cnt         <= '0;
      bus.clr_cmd_rdy <= 1'b0;
      bus.send_resp   <= 1'b0;
      bus.resp        <= 8'h00;
      strt_cal        <= 1'b0;
      motors_off      <= 1'b1;
      d_ptch          <= '0;
      d_roll          <= '0;
      d_yaw           <= '0;
      thrst           <= '0;
    end else begin
      state           <= state_nxt;
      cal_cnt         <= cal_cnt_nxt;
      bus.clr_cmd_rdy <= clr_nxt;
      bus.send_resp   <= send_nxt;
      bus.resp        <= resp_nxt;
      strt_cal        <= strt_nxt;
      motors_off      <= motors_nxt;
      d_ptch          <= ptch_nxt;
      d_roll          <= roll_nxt;
      d_yaw           <= yaw_nxt;
      thrst           <= thrst_nxt;
    end
  end

endmodule
